// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM encoding and
// counter-width helpers.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

  // A single-step configuration still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (clog2(steps) > 0) ? clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/ripple_chunk.sv
// Combinational BPC-bit ripple-carry adder slice; also exposes the carry
// into its MSB so the caller can form signed overflow.
module ripple_chunk #(
  parameter int unsigned BPC = 1
) (
  input  logic [BPC-1:0] i_a,
  input  logic [BPC-1:0] i_b,
  input  logic           i_cin,
  output logic [BPC-1:0] o_sum,
  output logic           o_cout,
  output logic           o_c_msb_in
);

  logic [BPC:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < BPC; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout     = w_c[BPC];
  assign o_c_msb_in = w_c[BPC-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: latches operands on start, processes BPC bits per
// clock LSB first, then presents sum/cout/overflow with a one-cycle done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned BpcSafe = (BPC == 0) ? 1 : BPC;
  localparam int unsigned STEPS   = WIDTH / BpcSafe;
  localparam int unsigned CW      = cnt_width(STEPS);

  if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BpcSafe) != 0) begin : g_bad_params
    $error("serial_addsub: illegal WIDTH/BPC combination");
  end

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_step, w_step_nxt;
  logic [WIDTH-1:0] r_a_sh, w_a_sh_nxt;
  logic [WIDTH-1:0] r_b_sh, w_b_sh_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic [WIDTH-1:0] r_sum, w_sum_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic [BPC-1:0]   w_ch_sum;
  logic             w_ch_cout;
  logic             w_ch_c_msb_in;
  logic [WIDTH-1:0] w_res_shift;
  logic             w_last;

  ripple_chunk #(
    .BPC(BPC)
  ) u_chunk (
    .i_a       (r_a_sh[BPC-1:0]),
    .i_b       (r_b_sh[BPC-1:0]),
    .i_cin     (r_carry),
    .o_sum     (w_ch_sum),
    .o_cout    (w_ch_cout),
    .o_c_msb_in(w_ch_c_msb_in)
  );

  // New chunk enters from the top so the LSB chunk ends up at bit 0.
  assign w_res_shift = (r_res >> BPC) | (WIDTH'(w_ch_sum) << (WIDTH - BPC));
  assign w_last      = (r_step == CW'(STEPS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_a_sh_nxt  = r_a_sh;
    w_b_sh_nxt  = r_b_sh;
    w_res_nxt   = r_res;
    w_carry_nxt = r_carry;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (i_start) begin
          w_state_nxt = RUN;
          w_a_sh_nxt  = i_a;
          w_b_sh_nxt  = i_sub ? ~i_b : i_b;
          // Subtraction becomes a + ~b + ~cin.
          w_carry_nxt = i_cin ^ i_sub;
          w_step_nxt  = '0;
          w_res_nxt   = '0;
        end
      end
      RUN: begin
        w_a_sh_nxt  = r_a_sh >> BPC;
        w_b_sh_nxt  = r_b_sh >> BPC;
        w_carry_nxt = w_ch_cout;
        w_res_nxt   = w_res_shift;
        w_step_nxt  = r_step + CW'(1);
        if (w_last) begin
          w_state_nxt = DONE;
          w_step_nxt  = '0;
          w_sum_nxt   = w_res_shift;
          w_cout_nxt  = w_ch_cout;
          w_ovf_nxt   = w_ch_c_msb_in ^ w_ch_cout;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_a_sh  <= w_a_sh_nxt;
      r_b_sh  <= w_b_sh_nxt;
      r_res   <= w_res_nxt;
      r_carry <= w_carry_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_busy     = (r_state == RUN);
  assign o_done     = (r_state == DONE);
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;

endmodule
